// File: rtl/cdp1802_dma_int_responder.sv
// CPU-side DMA/interrupt responder for the 1802 core and the CDP1861 Pixie.
// It samples requests at machine-cycle decision ticks and inserts S2 (DMA) or S3 (interrupt) cycles.
module cdp1802_dma_int_responder #(
  parameter logic [15:0] R0_RESET = 16'h0000,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [1:0]        core_sc,
  input  logic              core_cyc_end,
  input  logic              ie,
  input  logic              dma_out_n,
  input  logic              dma_in_n,
  input  logic              int_req,
  input  logic              r0_wr,
  input  logic [15:0]       r0_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        dma_in_data,
  output logic [1:0]        SC,
  output logic              core_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        dma_data,
  output logic              dma_strobe,
  output logic              int_ack,
  output logic [15:0]       r0
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    S2_OUT = 2'b01,
    S2_IN  = 2'b10,
    S3_INT = 2'b11
  } state_t;

  state_t      state_q, state_d, pick;
  logic [15:0] r0_q, r0_d;
  logic [7:0]  data_q, data_d;
  logic        strobe_q, strobe_d;
  logic        ack_q, ack_d;

  // Request priority applied at every decision tick: DMA-in, DMA-out, then enabled interrupt.
  always_comb begin
    pick = IDLE;
    if (!dma_in_n)
      pick = S2_IN;
    else if (!dma_out_n)
      pick = S2_OUT;
    else if (int_req && ie)
      pick = S3_INT;
  end

  always_comb begin
    state_d  = state_q;
    r0_d     = r0_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    ack_d    = 1'b0;
    if (clk_enable) begin
      unique case (state_q)
        IDLE: begin
          if (r0_wr)
            r0_d = r0_wdata;
          if (core_cyc_end && core_sc == 2'b01)
            state_d = pick;
        end
        S2_OUT: begin
          data_d   = mem_rdata;
          strobe_d = 1'b1;
          r0_d     = r0_q + 16'd1;
          state_d  = pick;
        end
        S2_IN: begin
          r0_d    = r0_q + 16'd1;
          state_d = pick;
        end
        S3_INT: begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      r0_q     <= R0_RESET;
      data_q   <= '0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r0_q     <= r0_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
    end
  end

  // Bus-side outputs decode directly from the registered state, so they only move one clk after a tick.
  always_comb begin
    SC        = core_sc;
    core_hold = 1'b0;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      S2_OUT: begin
        SC        = 2'b10;
        core_hold = 1'b1;
        mem_addr  = ADDR_W'(r0_q);
        mem_rd    = 1'b1;
      end
      S2_IN: begin
        SC        = 2'b10;
        core_hold = 1'b1;
        mem_addr  = ADDR_W'(r0_q);
        mem_wr    = 1'b1;
        mem_wdata = dma_in_data;
      end
      S3_INT: begin
        SC        = 2'b11;
        core_hold = 1'b1;
      end
      default: ;
    endcase
  end

  assign dma_data   = data_q;
  assign dma_strobe = strobe_q;
  assign int_ack    = ack_q;
  assign r0         = r0_q;

endmodule
